// File: rtl/led_event_scheduler_pkg.sv
// Shared encodings for the LED event scheduler: FSM states, grant codes and
// the fixed-priority grant selector.
package led_event_scheduler_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_ISSUE = 2'd1,
        SCHED_DWELL = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ERR  = 2'd1,
        GRANT_VEND = 2'd2,
        GRANT_CHG  = 2'd3
    } grant_e;

    // Error always wins. An aged change jumps ahead of vend, otherwise vend
    // goes before change.
    function automatic grant_e pick_grant(input logic err_p,
                                          input logic vend_p,
                                          input logic chg_p,
                                          input logic chg_aged);
        if (err_p)            return GRANT_ERR;
        if (chg_p && chg_aged) return GRANT_CHG;
        if (vend_p)           return GRANT_VEND;
        if (chg_p)            return GRANT_CHG;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/led_event_scheduler_tick.sv
// tick_prescaler: divides clk by TICK_DIV to produce the dwell tick.
// The count is held at 0 while clr_i is high so every dwell starts on a
// fresh prescaler period.
module tick_prescaler #(
    parameter logic [23:0] TICK_DIV = 24'd12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;
    logic        at_top;

    assign at_top = (cnt_q == (TICK_DIV - 24'd1));

    // Next count: wrap at TICK_DIV-1, hold at zero while cleared.
    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (clr_i || at_top) begin
            cnt_d = 24'd0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = at_top && !clr_i;

endmodule

// File: rtl/led_event_scheduler.sv
// led_event_scheduler: arbitrates LED feedback requests from the vend FSM,
// fault detector and change unit onto the LED feedback driver.
// Each requester has a one-deep pending slot; grants follow error > vend >
// change and each grant is held for DWELL_TICKS prescaler ticks.
// Optional build macro LED_SCHED_AGING_EN: a pending change that has been
// bypassed by AGE_LIMIT vend grants is promoted above vend.
//
// state       | meaning
// ------------+----------------------------------------------------------
// SCHED_IDLE  | nothing active; next cycle issues the highest pending slot
// SCHED_ISSUE | one cycle: event pulse or change_returning rise is visible
// SCHED_DWELL | holding the grant until DWELL_TICKS ticks have elapsed;
//             | a pending error aborts a vend/change dwell
module led_event_scheduler
    import led_event_scheduler_pkg::*;
#(
    parameter logic [23:0] TICK_DIV    = 24'd12_000_000,
    parameter int          DWELL_TICKS = 4,
    parameter int          AGE_LIMIT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       error_req,
    input  logic       vend_req,
    input  logic [1:0] vend_item,
    input  logic       change_req,
    input  logic [7:0] change_amt,
    output logic       error_event,
    output logic       vend_event,
    output logic [1:0] item_select,
    output logic       change_returning,
    output logic [7:0] change_due,
    output logic [1:0] grant,
    output logic       busy,
    output logic [7:0] drop_count
);

    localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);

    sched_state_e state_q;
    grant_e       grant_q;
    logic [3:0]   dwell_q;

    logic       err_p_q, err_p_d;
    logic       vend_p_q, vend_p_d;
    logic       chg_p_q, chg_p_d;
    logic [1:0] item_p_q, item_p_d;
    logic [7:0] amt_p_q, amt_p_d;
    logic [7:0] drop_q, drop_d;

    logic       error_event_q;
    logic       vend_event_q;
    logic [1:0] item_select_q;
    logic       change_returning_q;
    logic [7:0] change_due_q;
    logic       busy_q;

    logic       tick;
    logic       chg_aged;
    logic       preempt;
    grant_e     launch;

    logic       err_clr, vend_clr, chg_clr;
    logic       err_drop, vend_drop, chg_drop;
    logic [1:0] n_drop;
    logic [8:0] drop_sum;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != SCHED_DWELL),
        .tick_o (tick)
    );

    // Decide whether a grant launches this cycle and which slot it takes.
    always_comb begin
        launch  = GRANT_NONE;
        preempt = (state_q == SCHED_DWELL) && err_p_q && (grant_q != GRANT_ERR);
        if (preempt) begin
            launch = GRANT_ERR;
        end else if (state_q == SCHED_IDLE) begin
            launch = pick_grant(err_p_q, vend_p_q, chg_p_q, chg_aged);
        end
    end

    // Pending slots: a new request beats a same-cycle grant of its slot;
    // a request into an occupied, non-granted slot is dropped.
    always_comb begin
        err_clr   = (launch == GRANT_ERR);
        vend_clr  = (launch == GRANT_VEND);
        chg_clr   = (launch == GRANT_CHG);

        err_drop  = error_req  && err_p_q  && !err_clr;
        vend_drop = vend_req   && vend_p_q && !vend_clr;
        chg_drop  = change_req && chg_p_q  && !chg_clr;

        err_p_d   = error_req  | (err_p_q  & ~err_clr);
        vend_p_d  = vend_req   | (vend_p_q & ~vend_clr);
        chg_p_d   = change_req | (chg_p_q  & ~chg_clr);

        item_p_d  = item_p_q;
        if (vend_req && (!vend_p_q || vend_clr)) begin
            item_p_d = vend_item;
        end
        amt_p_d   = amt_p_q;
        if (change_req && (!chg_p_q || chg_clr)) begin
            amt_p_d = change_amt;
        end

        n_drop    = {1'b0, err_drop} + {1'b0, vend_drop} + {1'b0, chg_drop};
        drop_sum  = {1'b0, drop_q} + {7'd0, n_drop};
        drop_d    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Slot and drop-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_p_q  <= 1'b0;
            vend_p_q <= 1'b0;
            chg_p_q  <= 1'b0;
            item_p_q <= 2'd0;
            amt_p_q  <= 8'd0;
            drop_q   <= 8'd0;
        end else begin
            err_p_q  <= err_p_d;
            vend_p_q <= vend_p_d;
            chg_p_q  <= chg_p_d;
            item_p_q <= item_p_d;
            amt_p_q  <= amt_p_d;
            drop_q   <= drop_d;
        end
    end

`ifdef LED_SCHED_AGING_EN
    logic [1:0] age_q;
    logic [1:0] age_d;

    // Age counts vend grants that bypassed a pending change.
    always_comb begin
        age_d = age_q;
        if (launch == GRANT_CHG) begin
            age_d = 2'd0;
        end else if ((launch == GRANT_VEND) && chg_p_q && (age_q != 2'd3)) begin
            age_d = age_q + 2'd1;
        end
    end

    // Age register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= 2'd0;
        end else begin
            age_q <= age_d;
        end
    end

    assign chg_aged = (int'(age_q) >= AGE_LIMIT);
`else
    logic [1:0] age_limit_unused;
    assign age_limit_unused = 2'(AGE_LIMIT);
    assign chg_aged         = 1'b0;
`endif

    // Scheduler FSM with registered driver outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= SCHED_IDLE;
            grant_q            <= GRANT_NONE;
            dwell_q            <= 4'd0;
            busy_q             <= 1'b0;
            error_event_q      <= 1'b0;
            vend_event_q       <= 1'b0;
            item_select_q      <= 2'd0;
            change_returning_q <= 1'b0;
            change_due_q       <= 8'd0;
        end else begin
            error_event_q <= 1'b0;
            vend_event_q  <= 1'b0;
            if (launch != GRANT_NONE) begin
                // Covers both a fresh issue from IDLE and an error preempting
                // a dwell; a preempted change drops its outputs here.
                state_q            <= SCHED_ISSUE;
                grant_q            <= launch;
                busy_q             <= 1'b1;
                error_event_q      <= (launch == GRANT_ERR);
                vend_event_q       <= (launch == GRANT_VEND);
                change_returning_q <= (launch == GRANT_CHG);
                change_due_q       <= (launch == GRANT_CHG) ? amt_p_q : 8'd0;
                if (launch == GRANT_VEND) begin
                    item_select_q <= item_p_q;
                end
            end else begin
                case (state_q)
                    SCHED_ISSUE: begin
                        state_q <= SCHED_DWELL;
                        dwell_q <= 4'd0;
                    end
                    SCHED_DWELL: begin
                        if (tick) begin
                            if (dwell_q == DWELL_LAST) begin
                                state_q            <= SCHED_IDLE;
                                grant_q            <= GRANT_NONE;
                                busy_q             <= 1'b0;
                                change_returning_q <= 1'b0;
                                change_due_q       <= 8'd0;
                            end else begin
                                dwell_q <= dwell_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= SCHED_IDLE;
                        grant_q <= GRANT_NONE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign error_event      = error_event_q;
    assign vend_event       = vend_event_q;
    assign item_select      = item_select_q;
    assign change_returning = change_returning_q;
    assign change_due       = change_due_q;
    assign grant            = grant_q;
    assign busy             = busy_q;
    assign drop_count       = drop_q;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Testbench for led_event_scheduler: directed scenarios plus random traffic,
// checked by a scoreboard fed from a cycle-level reference model that tracks
// dwell as a remaining-cycle count.
module tb_led_event_scheduler;

    localparam logic [23:0] TD = 24'd4;
    localparam int          DT = 2;
    localparam int          AL = 1;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       error_req  = 1'b0;
    logic       vend_req   = 1'b0;
    logic [1:0] vend_item  = 2'd0;
    logic       change_req = 1'b0;
    logic [7:0] change_amt = 8'd0;

    logic       error_event;
    logic       vend_event;
    logic [1:0] item_select;
    logic       change_returning;
    logic [7:0] change_due;
    logic [1:0] grant;
    logic       busy;
    logic [7:0] drop_count;

    led_event_scheduler #(
        .TICK_DIV    (TD),
        .DWELL_TICKS (DT),
        .AGE_LIMIT   (AL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .error_req        (error_req),
        .vend_req         (vend_req),
        .vend_item        (vend_item),
        .change_req       (change_req),
        .change_amt       (change_amt),
        .error_event      (error_event),
        .vend_event       (vend_event),
        .item_select      (item_select),
        .change_returning (change_returning),
        .change_due       (change_due),
        .grant            (grant),
        .busy             (busy),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int kind;
        int pay;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  log_q[$];

    // Reference model state (kinds: 0 none, 1 error, 2 vend, 3 change).
    int cyc       = 0;
    int m_phase   = 0;   // 0 idle, 1 issue, 2 dwell
    int m_cur     = 0;
    int m_rem     = 0;
    int m_drops   = 0;
    int m_age     = 0;
    int m_sel     = 0;
    int m_ret     = 0;
    int m_due     = 0;
    bit m_e       = 0;
    bit m_v       = 0;
    bit m_c       = 0;
    int m_item    = 0;
    int m_amt     = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int  launch;
        int  nd;
        bit  aged;
        ev_t ev;
        if (!rst_n) begin
            m_phase = 0; m_cur = 0; m_rem = 0; m_drops = 0; m_age = 0;
            m_sel = 0; m_ret = 0; m_due = 0; m_e = 0; m_v = 0; m_c = 0;
            m_item = 0; m_amt = 0;
            exp_q.delete();
        end else begin
            cyc++;
            aged = 0;
`ifdef LED_SCHED_AGING_EN
            aged = (m_age >= AL);
`endif
            launch = 0;
            if (m_phase == 0) begin
                if (m_e)                    launch = 1;
                else if (m_v && !(m_c && aged)) launch = 2;
                else if (m_c)               launch = 3;
            end else if (m_phase == 2 && m_cur != 1 && m_e) begin
                launch = 1;
            end

            nd = 0;
            if (error_req  && m_e && launch != 1) nd++;
            if (vend_req   && m_v && launch != 2) nd++;
            if (change_req && m_c && launch != 3) nd++;
            m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;

            if (launch == 3) m_age = 0;
            else if (launch == 2 && m_c && m_age < 3) m_age++;

            if (launch != 0) begin
                ev.kind = launch;
                ev.pay  = (launch == 2) ? m_item : (launch == 3) ? m_amt : 0;
                ev.cyc  = cyc;
                exp_q.push_back(ev);
                if (launch == 2) m_sel = m_item;
                m_ret   = (launch == 3) ? 1 : 0;
                m_due   = (launch == 3) ? m_amt : 0;
                m_phase = 1;
                m_cur   = launch;
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_rem   = DT * int'(TD);
            end else if (m_phase == 2) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_phase = 0; m_cur = 0; m_ret = 0; m_due = 0;
                end
            end

            if (launch == 1) m_e = 0;
            if (launch == 2) m_v = 0;
            if (launch == 3) m_c = 0;
            if (error_req && !m_e) m_e = 1;
            if (vend_req && !m_v) begin m_v = 1; m_item = int'(vend_item); end
            if (change_req && !m_c) begin m_c = 1; m_amt = int'(change_amt); end
        end
    end

    // Monitor state
    bit prev_ret  = 0;
    int ev_count  = 0;
    int busy_run  = 0;
    int last_busy = 0;
    int ret_run   = 0;
    int last_ret  = 0;

    function automatic int log_at(input int i);
        return (log_q.size() > i) ? log_q[i] : -1;
    endfunction

    function automatic int dut_levels();
        logic [21:0] v;
        v = {busy, grant, drop_count, change_returning, change_due, item_select};
        return int'(v);
    endfunction

    function automatic int dut_all();
        logic [23:0] v;
        v = {error_event, vend_event, item_select, change_returning, change_due,
             grant, busy, drop_count};
        return int'(v);
    endfunction

    always @(negedge clk) begin : monitor
        ev_t e;
        int  kind;
        int  pay;
        bit  got;
        int  mlev;
        got  = 0;
        kind = 0;
        pay  = 0;
        if (error_event) begin kind = 1; got = 1; end
        if (vend_event) begin kind = got ? 9 : 2; pay = int'(item_select); got = 1; end
        if (change_returning && !prev_ret) begin
            kind = got ? 9 : 3; pay = int'(change_due); got = 1;
        end
        prev_ret = change_returning;
        if (got) begin
            ev_count++;
            log_q.push_back(kind);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", kind, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_payload", pay, e.pay);
                chk("event_cycle", cyc, e.cyc);
            end
        end
        if (exp_q.size() != 0) begin
            chk("missing_event", exp_q.size(), 0);
            exp_q.delete();
        end
        mlev = ((m_phase != 0 ? 1 : 0) << 21) | (m_cur << 19) | (m_drops << 11) |
               (m_ret << 10) | (m_due << 2) | m_sel;
        chk("levels", dut_levels(), mlev);
        if (busy) busy_run++;
        else if (busy_run > 0) begin last_busy = busy_run; busy_run = 0; end
        if (change_returning) ret_run++;
        else if (ret_run > 0) begin last_ret = ret_run; ret_run = 0; end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit er, input bit vr, input int vi, input bit cr, input int ca);
        @(negedge clk);
        error_req  = er;
        vend_req   = vr;
        vend_item  = 2'(vi);
        change_req = cr;
        change_amt = 8'(ca);
        @(negedge clk);
        error_req  = 1'b0;
        vend_req   = 1'b0;
        change_req = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ev_before;

        wait_n(3);
        chk("reset_outputs", dut_all(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_n(3);

        // Single vend
        log_q.delete();
        drive(0, 1, 2, 0, 0);
        wait_n(15);
        chk("single_vend_busy_len", last_busy, 9);
        chk("single_vend_grants", log_q.size(), 1);
        chk("single_vend_item", int'(item_select), 2);

        // Simultaneous requests
        log_q.delete();
        drive(1, 1, 1, 1, 5);
        wait_n(40);
        chk("simul_grants", log_q.size(), 3);
        chk("simul_first", log_at(0), 1);
        chk("simul_second", log_at(1), 2);
        chk("simul_third", log_at(2), 3);
        chk("simul_change_len", last_ret, 9);

        // Duplicate request during a change dwell
        log_q.delete();
        drive(0, 0, 0, 1, 7);
        wait_n(3);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 3, 0, 0);
        chk("dup_drop_count", int'(drop_count), 1);
        wait_n(25);
        chk("dup_order", log_at(1), 2);
        chk("dup_item_kept", int'(item_select), 1);

        // Preemption of a change dwell by an error
        log_q.delete();
        drive(0, 0, 0, 1, 8'h33);
        wait_n(4);
        drive(1, 0, 0, 0, 0);
        wait_n(25);
        chk("preempt_first", log_at(0), 3);
        chk("preempt_second", log_at(1), 1);
        chk("preempt_change_len", last_ret, 6);
        chk("preempt_idle_after", int'(busy), 0);

        // Aging: change pending while vends keep arriving
        log_q.delete();
        drive(0, 1, 0, 1, 9);
        wait_n(3);
        drive(0, 1, 3, 0, 0);
        for (int k = 0; k < 3; k++) begin
            wait_n(8);
            drive(0, 1, k, 0, 0);
        end
        wait_n(60);
`ifdef LED_SCHED_AGING_EN
        chk("aging_second_grant", log_at(1), 3);
`else
        chk("aging_second_grant", log_at(1), 2);
`endif

        // Reset mid-dwell
        drive(0, 1, 1, 0, 0);
        wait_n(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_dwell", dut_all(), 0);
        wait_n(2);
        rst_n = 1'b1;
        ev_before = ev_count;
        wait_n(15);
        chk("no_event_after_reset", ev_count, ev_before);

        // Random traffic: light then heavy
        for (int i = 0; i < 2600; i++) begin
            int r;
            r = (i < 1000) ? 6 : 2;
            @(negedge clk);
            error_req  = ($urandom_range(r * 3 - 1, 0) == 0);
            vend_req   = ($urandom_range(r - 1, 0) == 0);
            vend_item  = 2'($urandom_range(3, 0));
            change_req = ($urandom_range(r - 1, 0) == 0);
            change_amt = 8'($urandom_range(255, 0));
        end
        @(negedge clk);
        error_req  = 1'b0;
        vend_req   = 1'b0;
        change_req = 1'b0;
        wait_n(60);
        chk("drop_saturated", int'(drop_count), 255);
        chk("final_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
